pc_fetch_unit: RTL and testbench

Program counter and instruction fetch stage of the RISC CPU. Holds the PC, fetches one instruction at a time from instruction memory over a req/ack handshake, and presents it to decode. On each instruction retire it consumes the branch-select bit from the branch-equal select stage (`M`) and the branch target, and chooses the next PC: target or PC+1. A bounded wait counter flags an unresponsive memory.

---
 rtl/pc_fetch_unit_pkg.sv | 23 ++
 rtl/pc_fetch_unit_pc_next_sel.sv | 22 ++
 rtl/pc_fetch_unit.sv | 122 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// Module      : pc_fetch_unit_pkg
// Description : Shared state encodings and default widths for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

    localparam int c_DEFAULT_ADDR_W  = 8;
    localparam int c_DEFAULT_INSTR_W = 16;
    localparam int c_WAIT_CNT_W      = 8;

    typedef logic [1:0] fetchState_t;

    localparam fetchState_t c_IDLE  = 2'd0;
    localparam fetchState_t c_FETCH = 2'd1;
    localparam fetchState_t c_ISSUE = 2'd2;
    localparam fetchState_t c_FAULT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// ============================================================================
// Module      : pc_next_sel
// Description : Combinational next-PC selector, branch target or PC+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              brTaken,
    input  logic [ADDR_W-1:0] brTarget,
    output logic [ADDR_W-1:0] nextPc
);

    // Sequential increment wraps naturally at 2^ADDR_W.
    assign nextPc = brTaken ? brTarget : pc + ADDR_W'(1);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : PC register and single-outstanding instruction fetch with a
//               bounded memory wait and sticky timeout fault.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = c_DEFAULT_ADDR_W,
    parameter int INSTR_W  = c_DEFAULT_INSTR_W,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               fault
);

    localparam logic [ADDR_W-1:0]       c_RESET_PC  = ADDR_W'(RESET_PC);
    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LAST = c_WAIT_CNT_W'(TIMEOUT - 1);

    fetchState_t             r_state;
    fetchState_t             w_stateNext;
    logic [ADDR_W-1:0]       r_pc;
    logic [ADDR_W-1:0]       w_nextPc;
    logic [INSTR_W-1:0]      r_instr;
    logic [c_WAIT_CNT_W-1:0] r_waitCnt;
    logic                    w_ackTaken;
    logic                    w_consume;

    assign w_ackTaken = (r_state == c_FETCH) && imem_ack;
    assign w_consume  = (r_state == c_ISSUE) && !stall;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pcNextSel (
        .pc       (r_pc),
        .brTaken  (br_taken),
        .brTarget (br_target),
        .nextPc   (w_nextPc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE:  w_stateNext = c_FETCH;
            c_FETCH: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    w_stateNext = c_ISSUE;
                end else if (r_waitCnt == c_WAIT_LAST) begin
                    w_stateNext = c_FAULT;
                end
            end
            c_ISSUE: begin
                if (!stall) begin
                    w_stateNext = c_FETCH;
                end
            end
            c_FAULT: w_stateNext = c_FAULT;
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fault       = 1'b0;
        case (r_state)
            c_FETCH: imem_req    = 1'b1;
            c_ISSUE: instr_valid = 1'b1;
            c_FAULT: fault       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= c_RESET_PC;
            r_instr   <= '0;
            r_waitCnt <= '0;
        end else begin
            if (w_ackTaken) begin
                r_instr   <= imem_data;
                r_waitCnt <= '0;
            end else if (r_state == c_FETCH) begin
                r_waitCnt <= r_waitCnt + c_WAIT_CNT_W'(1);
            end
            if (w_consume) begin
                r_pc <= w_nextPc;
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        stall;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        fault;

    logic        memOn;
    logic        ackForce;
    int          checkCount;
    int          failCount;

    // Memory image: address A holds 0xA0 followed by (A - 0x0F).
    assign imem_ack  = memOn ? imem_req : ackForce;
    assign imem_data = {8'hA0, imem_addr - 8'h0F};

    pc_fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (8'h10),
        .TIMEOUT  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst        = 1'b1;
        memOn      = 1'b0;
        ackForce   = 1'b0;
        br_taken   = 1'b0;
        br_target  = 8'h00;
        stall      = 1'b0;

        tick(); tick(); tick();
        checkVal("rst_req",   32'(imem_req),    32'h0);
        checkVal("rst_addr",  32'(imem_addr),   32'h10);
        checkVal("rst_pc",    32'(pc),          32'h10);
        checkVal("rst_instr", 32'(instr),       32'h0);
        checkVal("rst_valid", 32'(instr_valid), 32'h0);
        checkVal("rst_fault", 32'(fault),       32'h0);

        rst   = 1'b0;
        memOn = 1'b1;
        tick();
        checkVal("first_req",  32'(imem_req),  32'h1);
        checkVal("first_addr", 32'(imem_addr), 32'h10);
        tick();
        checkVal("first_instr", 32'(instr),       32'hA001);
        checkVal("first_valid", 32'(instr_valid), 32'h1);
        checkVal("issue_noreq", 32'(imem_req),    32'h0);

        for (int i = 1; i <= 3; i++) begin
            tick();
            checkVal("seq_addr",  32'(imem_addr),   32'h10 + 32'(i));
            checkVal("seq_req",   32'(imem_req),    32'h1);
            checkVal("seq_vclr",  32'(instr_valid), 32'h0);
            tick();
            checkVal("seq_instr", 32'(instr),       32'hA001 + 32'(i));
        end

        // Branch offered only while stalled must not be taken.
        stall     = 1'b1;
        br_taken  = 1'b1;
        br_target = 8'h40;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkVal("stall_instr", 32'(instr),       32'hA004);
            checkVal("stall_pc",    32'(pc),          32'h13);
            checkVal("stall_req",   32'(imem_req),    32'h0);
            checkVal("stall_valid", 32'(instr_valid), 32'h1);
        end
        stall    = 1'b0;
        br_taken = 1'b0;
        tick();
        checkVal("resume_addr", 32'(imem_addr), 32'h14);
        checkVal("resume_req",  32'(imem_req),  32'h1);
        tick();
        checkVal("resume_instr", 32'(instr), 32'hA005);

        br_taken  = 1'b1;
        br_target = 8'h40;
        tick();
        br_taken = 1'b0;
        checkVal("br_addr", 32'(imem_addr), 32'h40);
        tick();
        checkVal("br_instr", 32'(instr), 32'hA031);

        br_taken  = 1'b1;
        br_target = 8'hFF;
        tick();
        br_taken = 1'b0;
        checkVal("brff_addr", 32'(imem_addr), 32'hFF);
        tick();
        checkVal("brff_instr", 32'(instr), 32'hA0F0);
        tick();
        checkVal("wrap_addr", 32'(imem_addr), 32'h00);

        // Two wait cycles, ack arrives on the last cycle before timeout.
        memOn    = 1'b0;
        ackForce = 1'b0;
        tick(); tick();
        checkVal("wait_valid", 32'(instr_valid), 32'h0);
        checkVal("wait_req",   32'(imem_req),    32'h1);
        ackForce = 1'b1;
        tick();
        checkVal("wait_instr", 32'(instr),       32'hA0F1);
        checkVal("wait_gotv",  32'(instr_valid), 32'h1);
        checkVal("wait_fault", 32'(fault),       32'h0);
        stall = 1'b1;
        tick();
        checkVal("ack_in_issue", 32'(instr), 32'hA0F1);

        stall    = 1'b0;
        ackForce = 1'b0;
        tick();
        checkVal("to_addr", 32'(imem_addr), 32'h01);
        tick(); tick();
        checkVal("to_pre_fault", 32'(fault),    32'h0);
        checkVal("to_pre_req",   32'(imem_req), 32'h1);
        tick();
        checkVal("to_fault", 32'(fault),       32'h1);
        checkVal("to_req",   32'(imem_req),    32'h0);
        checkVal("to_valid", 32'(instr_valid), 32'h0);
        ackForce = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkVal("fault_sticky", 32'(fault),       32'h1);
            checkVal("fault_novld",  32'(instr_valid), 32'h0);
        end

        #2;
        rst = 1'b1;
        #1;
        checkVal("arst_fault", 32'(fault),     32'h0);
        checkVal("arst_addr",  32'(imem_addr), 32'h10);
        checkVal("arst_req",   32'(imem_req),  32'h0);
        tick();
        rst      = 1'b0;
        ackForce = 1'b0;
        memOn    = 1'b1;
        tick();
        checkVal("re_req",  32'(imem_req),  32'h1);
        checkVal("re_addr", 32'(imem_addr), 32'h10);
        tick();
        checkVal("re_instr", 32'(instr),       32'hA001);
        checkVal("re_valid", 32'(instr_valid), 32'h1);

        // Reset asserted during a pending fetch drops the request at once.
        memOn = 1'b0;
        tick();
        checkVal("mid_req", 32'(imem_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkVal("mid_rst_req",   32'(imem_req),    32'h0);
        checkVal("mid_rst_valid", 32'(instr_valid), 32'h0);
        checkVal("mid_rst_instr", 32'(instr),       32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

`default_nettype wire
